// File: rtl/src_bank_writer.sv
// Round-robin write controller feeding the 16-bank source RAM write port.
// Optional early close on in_last is enabled by defining SRC_WR_FLUSH_EN.
module src_bank_writer #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          wr_en,
    output logic [AW-1:0] address_wr,
    output logic [7:0]    data,
    output logic [3:0]    ram_select_wr,
    output logic          bank_done,
    output logic [3:0]    done_bank,
    output logic [AW:0]   done_len,
    input  logic          rel_valid,
    input  logic [3:0]    rel_bank,
    output logic [15:0]   full_mask
);

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_FREE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cur_bank_q, cur_bank_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   full_mask_q, full_mask_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] address_wr_q, address_wr_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    ram_select_wr_q, ram_select_wr_d;
    logic          bank_done_q, bank_done_d;
    logic [3:0]    done_bank_q, done_bank_d;
    logic [AW:0]   done_len_q, done_len_d;

    logic          accept;
    logic          close;
    logic          last_close;
    logic [3:0]    next_bank;

`ifdef SRC_WR_FLUSH_EN
    assign last_close = in_last;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign last_close     = 1'b0;
`endif

    assign in_ready  = !rst && (state_q == FILL) && !full_mask_q[cur_bank_q];
    assign accept    = in_valid && in_ready;
    assign close     = accept && ((wr_ptr_q == AW'(DEPTH - 1)) || last_close);
    assign next_bank = cur_bank_q + 4'd1;

    always_comb begin
        state_d         = state_q;
        cur_bank_d      = cur_bank_q;
        wr_ptr_d        = wr_ptr_q;
        full_mask_d     = full_mask_q;
        wr_en_d         = 1'b0;
        address_wr_d    = address_wr_q;
        data_d          = data_q;
        ram_select_wr_d = ram_select_wr_q;
        bank_done_d     = 1'b0;
        done_bank_d     = done_bank_q;
        done_len_d      = done_len_q;

        // Clear first so a close on the same bit in the same cycle wins.
        if (rel_valid) full_mask_d[rel_bank] = 1'b0;

        if (accept) begin
            wr_en_d         = 1'b1;
            data_d          = in_data;
            address_wr_d    = wr_ptr_q;
            ram_select_wr_d = cur_bank_q;
            if (close) begin
                full_mask_d[cur_bank_q] = 1'b1;
                bank_done_d             = 1'b1;
                done_bank_d             = cur_bank_q;
                done_len_d              = {1'b0, wr_ptr_q} + (AW+1)'(1);
                wr_ptr_d                = '0;
                cur_bank_d              = next_bank;
            end else begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
        end

        case (state_q)
            FILL:      if (close && full_mask_d[next_bank]) state_d = WAIT_FREE;
            WAIT_FREE: if (!full_mask_q[cur_bank_q])        state_d = FILL;
            default:   state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= FILL;
            cur_bank_q      <= '0;
            wr_ptr_q        <= '0;
            full_mask_q     <= '0;
            wr_en_q         <= 1'b0;
            address_wr_q    <= '0;
            data_q          <= '0;
            ram_select_wr_q <= '0;
            bank_done_q     <= 1'b0;
            done_bank_q     <= '0;
            done_len_q      <= '0;
        end else begin
            state_q         <= state_d;
            cur_bank_q      <= cur_bank_d;
            wr_ptr_q        <= wr_ptr_d;
            full_mask_q     <= full_mask_d;
            wr_en_q         <= wr_en_d;
            address_wr_q    <= address_wr_d;
            data_q          <= data_d;
            ram_select_wr_q <= ram_select_wr_d;
            bank_done_q     <= bank_done_d;
            done_bank_q     <= done_bank_d;
            done_len_q      <= done_len_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign address_wr    = address_wr_q;
    assign data          = data_q;
    assign ram_select_wr = ram_select_wr_q;
    assign bank_done     = bank_done_q;
    assign done_bank     = done_bank_q;
    assign done_len      = done_len_q;
    assign full_mask     = full_mask_q;

endmodule

// File: tb/tb_src_bank_writer.sv
// Scoreboard bench for src_bank_writer: expected RAM writes and bank closes
// are queued when bytes are accepted and compared as the DUT emits them.
module tb_src_bank_writer;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = '0;
    logic          in_last = 1'b0;
    logic          wr_en;
    logic [AW-1:0] address_wr;
    logic [7:0]    data;
    logic [3:0]    ram_select_wr;
    logic          bank_done;
    logic [3:0]    done_bank;
    logic [AW:0]   done_len;
    logic          rel_valid = 1'b0;
    logic [3:0]    rel_bank = '0;
    logic [15:0]   full_mask;

    src_bank_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .wr_en(wr_en), .address_wr(address_wr), .data(data), .ram_select_wr(ram_select_wr),
        .bank_done(bank_done), .done_bank(done_bank), .done_len(done_len),
        .rel_valid(rel_valid), .rel_bank(rel_bank), .full_mask(full_mask)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned wr_cnt = 0;
    int unsigned done_cnt = 0;

    logic [21:0] wq[$];
    logic [14:0] dq[$];

    logic [3:0]    m_bank = '0;
    logic [AW-1:0] m_ptr  = '0;
    logic [15:0]   m_mask = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                wr_cnt++;
                if (wq.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
                else check("wr_bank_addr_data", {ram_select_wr, address_wr, data}, wq.pop_front());
            end
            if (bank_done) begin
                done_cnt++;
                if (dq.size() == 0) check("done_unexpected", 64'd1, 64'd0);
                else check("done_bank_len", {done_bank, done_len}, dq.pop_front());
            end
        end
    end

    task automatic model_accept(input logic [7:0] d, input logic l);
        logic cl;
        wq.push_back({m_bank, m_ptr, d});
`ifdef SRC_WR_FLUSH_EN
        cl = (m_ptr == AW'(DEPTH - 1)) || l;
`else
        cl = (m_ptr == AW'(DEPTH - 1));
`endif
        if (cl) begin
            dq.push_back({m_bank, {1'b0, m_ptr} + 11'd1});
            m_mask[m_bank] = 1'b1;
            m_bank = m_bank + 4'd1;
            m_ptr  = '0;
        end else begin
            m_ptr = m_ptr + 10'd1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int t = 0; t < 64; t++) begin
            #1;
            if (in_ready) begin
                model_accept(d, l);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0; rel_valid = 1'b0;
        end
    endtask

    task automatic release_bank(input logic [3:0] b);
        @(negedge clk);
        in_valid = 1'b0; rel_valid = 1'b1; rel_bank = b;
        m_mask[b] = 1'b0;
        @(negedge clk);
        rel_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1 check("in_ready_in_reset", in_ready, 64'd0);
        check("queues_empty_at_reset", wq.size() + dq.size(), 64'd0);
        m_bank = '0; m_ptr = '0; m_mask = '0;
        idle(2);
        rst = 1'b0;
        #1 check("in_ready_after_reset", in_ready, 64'd1);
        check("full_mask_after_reset", full_mask, 64'd0);
    endtask

    initial begin
        int unsigned acc;
        int unsigned w0;
        int unsigned d0;

        idle(3);
        #1;
        check("rst_in_ready", in_ready, 64'd0);
        check("rst_outputs", {wr_en, bank_done, full_mask, address_wr, ram_select_wr, done_len}, 64'd0);
        rst = 1'b0;
        #1 check("first_in_ready", in_ready, 64'd1);

        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
        idle(2);
        check("bank0_done_count", done_cnt, 64'd1);
        check("bank0_full_mask", full_mask, 64'h0001);

        for (int i = 0; i < 15 * DEPTH; i++) send_byte(8'(i * 7 + 3), 1'b0);
        idle(2);
        check("all_full_mask", full_mask, 64'hFFFF);
        check("all_full_mask_model", full_mask, m_mask);
        check("all_full_in_ready", in_ready, 64'd0);
        check("all_full_done_count", done_cnt, 64'd16);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'hEE;
            #1 check("blocked_in_ready", in_ready, 64'd0);
        end
        idle(1);

        @(negedge clk);
        rel_valid = 1'b1; rel_bank = 4'd0; m_mask[0] = 1'b0;
        #1 check("rel_cycle0_in_ready", in_ready, 64'd0);
        @(negedge clk);
        rel_valid = 1'b0;
        #1 check("rel_cycle1_in_ready", in_ready, 64'd0);
        @(negedge clk);
        #1 check("rel_cycle2_in_ready", in_ready, 64'd1);
        send_byte(8'h5A, 1'b0);
        idle(2);

        for (int b = 1; b < 15; b++) release_bank(4'(b));
        idle(2);
        check("partial_release_mask", full_mask, m_mask);

        w0 = wr_cnt; acc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            #1;
            if (in_valid && in_ready) begin
                model_accept(in_data, 1'b0);
                acc++;
            end
        end
        idle(3);
        check("throttle_wr_vs_accept", wr_cnt - w0, acc);
        check("throttle_accepted_some", acc > 500, 64'd1);

        release_bank(4'd7);
        idle(2);
        check("nonfull_release_mask", full_mask, m_mask);
        check("nonfull_release_bit15", full_mask[15], 64'd1);

        while (m_ptr != 10'd300 && n_bad == 0) send_byte(8'h33, 1'b0);
        idle(1);
        d0 = done_cnt;
        do_reset();
        check("reset_no_done", done_cnt, d0);
        send_byte(8'hA1, 1'b0);
        idle(2);

        do_reset();
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), i == 4);
        send_byte(8'h99, 1'b0);
        idle(2);
`ifdef SRC_WR_FLUSH_EN
        check("flush_done_count", done_cnt - d0, 64'd1);
        check("flush_mask", full_mask, 64'h0001);
`else
        check("noflush_done_count", done_cnt - d0, 64'd0);
        check("noflush_mask", full_mask, 64'h0000);
`endif

        idle(3);
        check("final_wq_empty", wq.size(), 64'd0);
        check("final_dq_empty", dq.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
